// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_pkg
// Description : Shared types and constants for the conditional-execution
//               stage: ARM condition-code encoding, NZCV flag bit indices
//               and the flag write-enable bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

    // ARM condition field encoding (instr[31:28])
    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_e;

    // Bit positions inside the 4-bit flag vector (Z N C V, MSB first)
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside the 2-bit flag write-enable
    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// ============================================================================
// Module      : cond_check
// Description : Purely combinational ARM condition-code evaluator.
//               Ports:
//                 cond_i   [3:0] in  : condition field
//                 flags_i  [3:0] in  : stored flags, Z N C V in bits 3..0
//                 cond_ex        out : condition passed
//               The reserved encoding 1111 never passes.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex
);

    logic w_z;
    logic w_n;
    logic w_c;
    logic w_v;

    assign w_z = flags_i[FLAG_Z];
    assign w_n = flags_i[FLAG_N];
    assign w_c = flags_i[FLAG_C];
    assign w_v = flags_i[FLAG_V];

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond_i))
            EQ:      cond_ex = w_z;
            NE:      cond_ex = ~w_z;
            CS:      cond_ex = w_c;
            CC:      cond_ex = ~w_c;
            MI:      cond_ex = w_n;
            PL:      cond_ex = ~w_n;
            VS:      cond_ex = w_v;
            VC:      cond_ex = ~w_v;
            HI:      cond_ex = w_c & ~w_z;
            LS:      cond_ex = ~w_c | w_z;
            GE:      cond_ex = (w_n == w_v);
            LT:      cond_ex = (w_n != w_v);
            GT:      cond_ex = ~w_z & (w_n == w_v);
            LE:      cond_ex = w_z | (w_n != w_v);
            AL:      cond_ex = 1'b1;
            default: cond_ex = 1'b0;   // NV: reserved, treated as never
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : cond_unit
// Description : Conditional-execution stage following the ALU. Holds the
//               NZCV flag register, evaluates the condition field against
//               the stored flags and registers the gated side-effect
//               controls into the EX/MEM boundary.
//               Ports:
//                 clk, rst_n          : clock, synchronous active-low reset
//                 stall_i, flush_i    : hold / kill the instruction in EX
//                 valid_i             : instruction present in EX
//                 cond_i      [3:0]   : condition field
//                 alu_flags   [3:0]   : ALU flags, Z N C V in bits 3..0
//                 flag_w_i    [1:0]   : [1] writes N,Z ; [0] writes C,V
//                 pc_src_i, reg_write_i, mem_write_i : ungated controls
//                 q_clr_i             : clear sticky overflow
//                 cond_ex_o           : combinational condition passed
//                 flags_o     [3:0]   : stored flags
//                 valid_o, pc_src_o, reg_write_o, mem_write_o : registered
//                 q_flag_o            : sticky overflow
//               Optional feature macro: COND_STICKY_OVF_EN (sticky Q flag).
//               Without it q_flag_o is constant 0 and q_clr_i is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_unit
    import cond_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall_i,
    input  logic       flush_i,
    input  logic       valid_i,
    input  logic [3:0] cond_i,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w_i,
    input  logic       pc_src_i,
    input  logic       reg_write_i,
    input  logic       mem_write_i,
    input  logic       q_clr_i,
    output logic       cond_ex_o,
    output logic [3:0] flags_o,
    output logic       valid_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic       mem_write_o,
    output logic       q_flag_o
);

    logic       w_cond_ex;
    logic       w_exec;
    logic       w_wr_nz;
    logic       w_wr_cv;

    logic [3:0] r_flags;
    logic       r_valid;
    logic       r_pc_src;
    logic       r_reg_write;
    logic       r_mem_write;

    // Condition always judged against the stored flags; flags written by
    // the previous instruction are already in r_flags, so no forwarding.
    cond_check u_cond_check (
        .cond_i  (cond_i),
        .flags_i (r_flags),
        .cond_ex (w_cond_ex)
    );

    assign w_exec  = valid_i & w_cond_ex & ~flush_i;
    assign w_wr_nz = w_exec & flag_w_i[FLAGW_NZ] & ~stall_i;
    assign w_wr_cv = w_exec & flag_w_i[FLAGW_CV] & ~stall_i;

    // Flag register: the NZ and CV halves have independent enables.
    // A flush clears w_exec, so it also suppresses any flag write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flags <= 4'b0000;
        end else begin
            if (w_wr_nz) begin
                r_flags[FLAG_N] <= alu_flags[FLAG_N];
                r_flags[FLAG_Z] <= alu_flags[FLAG_Z];
            end
            if (w_wr_cv) begin
                r_flags[FLAG_C] <= alu_flags[FLAG_C];
                r_flags[FLAG_V] <= alu_flags[FLAG_V];
            end
        end
    end

    // EX/MEM control register. Flush beats stall: it loads a bubble even
    // while the rest of the pipe is held. A failed condition still yields
    // a valid entry, but with every side effect cleared (a no-op).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_pc_src    <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (flush_i) begin
            r_valid     <= 1'b0;
            r_pc_src    <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_write <= 1'b0;
        end else if (!stall_i) begin
            r_valid     <= valid_i;
            r_pc_src    <= pc_src_i & w_exec;
            r_reg_write <= reg_write_i & w_exec;
            r_mem_write <= mem_write_i & w_exec;
        end
    end

`ifdef COND_STICKY_OVF_EN
    logic r_q_flag;

    // Set on any C,V write carrying V=1; clear when not stalled. Set wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q_flag <= 1'b0;
        end else if (w_wr_cv && alu_flags[FLAG_V]) begin
            r_q_flag <= 1'b1;
        end else if (q_clr_i && !stall_i) begin
            r_q_flag <= 1'b0;
        end
    end

    assign q_flag_o = r_q_flag;
`else
    logic w_unused_q_clr;

    assign w_unused_q_clr = q_clr_i;
    assign q_flag_o       = 1'b0;
`endif

    assign cond_ex_o   = w_cond_ex;
    assign flags_o     = r_flags;
    assign valid_o     = r_valid;
    assign pc_src_o    = r_pc_src;
    assign reg_write_o = r_reg_write;
    assign mem_write_o = r_mem_write;

endmodule : cond_unit
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_unit
// Description : Directed self-checking bench for cond_unit. Expected values
//               are hand-computed constants. Sticky-Q checks follow the
//               COND_STICKY_OVF_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_unit;

    logic       clk;
    logic       rst_n;
    logic       stall_i;
    logic       flush_i;
    logic       valid_i;
    logic [3:0] cond_i;
    logic [3:0] alu_flags;
    logic [1:0] flag_w_i;
    logic       pc_src_i;
    logic       reg_write_i;
    logic       mem_write_i;
    logic       q_clr_i;
    logic       cond_ex_o;
    logic [3:0] flags_o;
    logic       valid_o;
    logic       pc_src_o;
    logic       reg_write_o;
    logic       mem_write_o;
    logic       q_flag_o;

    int checks;
    int errors;

    localparam logic [3:0] C_EQ = 4'b0000;
    localparam logic [3:0] C_GE = 4'b1010;
    localparam logic [3:0] C_GT = 4'b1100;
    localparam logic [3:0] C_AL = 4'b1110;
    localparam logic [3:0] C_NV = 4'b1111;

    cond_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .cond_i      (cond_i),
        .alu_flags   (alu_flags),
        .flag_w_i    (flag_w_i),
        .pc_src_i    (pc_src_i),
        .reg_write_i (reg_write_i),
        .mem_write_i (mem_write_i),
        .q_clr_i     (q_clr_i),
        .cond_ex_o   (cond_ex_o),
        .flags_o     (flags_o),
        .valid_o     (valid_o),
        .pc_src_o    (pc_src_o),
        .reg_write_o (reg_write_o),
        .mem_write_o (mem_write_o),
        .q_flag_o    (q_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Registered outputs {valid, pc_src, reg_write, mem_write}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {valid_o, pc_src_o, reg_write_o, mem_write_o}, exp);
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n       = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        cond_i      = C_AL;
        alu_flags   = 4'b0000;
        flag_w_i    = 2'b00;
        pc_src_i    = 1'b0;
        reg_write_i = 1'b0;
        mem_write_i = 1'b0;
        q_clr_i     = 1'b0;
    endtask

    // Sweep all 16 conditions against the current stored flags
    task automatic sweep(input string tag, input logic [15:0] exp_vec);
        valid_i  = 1'b0;
        flag_w_i = 2'b00;
        for (int i = 0; i < 16; i++) begin
            cond_i = 4'(i);
            #1;
            chk($sformatf("%s_cond%0d", tag, i), {3'b000, cond_ex_o}, {3'b000, exp_vec[i]});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset with every input held high
        rst_n = 1'b0; stall_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1;
        cond_i = 4'b1111; alu_flags = 4'b1111; flag_w_i = 2'b11;
        pc_src_i = 1'b1; reg_write_i = 1'b1; mem_write_i = 1'b1; q_clr_i = 1'b1;
        tick();
        tick();
        chk("rst_flags", flags_o, 4'b0000);
        chk_ctl("rst_ctl", 4'b0000);
        chk("rst_q", {3'b000, q_flag_o}, 4'b0000);
        chk("rst_nv_cond", {3'b000, cond_ex_o}, 4'b0000);

        // AL flag write of Z=1
        idle();
        valid_i = 1'b1; cond_i = C_AL; flag_w_i = 2'b11; alu_flags = 4'b1000;
        #1;
        chk("al_cond", {3'b000, cond_ex_o}, 4'b0001);
        tick();
        chk("fw_flags", flags_o, 4'b1000);
        chk_ctl("fw_ctl", 4'b1000);

        // EQ now passes on stored Z, regardless of incoming alu_flags
        idle();
        valid_i = 1'b1; cond_i = C_EQ; reg_write_i = 1'b1; alu_flags = 4'b0000;
        #1;
        chk("eq_cond", {3'b000, cond_ex_o}, 4'b0001);
        tick();
        chk_ctl("eq_ctl", 4'b1010);
        chk("eq_flags", flags_o, 4'b1000);

        // NZ-only write -> flags 0100 (N=1), CV untouched (0)
        idle();
        valid_i = 1'b1; flag_w_i = 2'b10; alu_flags = 4'b0100;
        tick();
        chk("nz_flags", flags_o, 4'b0100);
        sweep("sw0100", 16'h6A9A);

        // Failed condition: GE with N=1,V=0
        idle();
        valid_i = 1'b1; cond_i = C_GE; mem_write_i = 1'b1; flag_w_i = 2'b11;
        alu_flags = 4'b1111; pc_src_i = 1'b1;
        #1;
        chk("ge_cond", {3'b000, cond_ex_o}, 4'b0000);
        tick();
        chk_ctl("ge_ctl", 4'b1000);
        chk("ge_flags", flags_o, 4'b0100);

        // Clear flags, then CV-only write of 1111 -> 0011
        idle();
        valid_i = 1'b1; flag_w_i = 2'b11; alu_flags = 4'b0000;
        tick();
        chk("clr_flags", flags_o, 4'b0000);
        idle();
        valid_i = 1'b1; flag_w_i = 2'b01; alu_flags = 4'b1111;
        tick();
        chk("cv_flags", flags_o, 4'b0011);
        sweep("sw0011", 16'h6966);

        // Load a pc redirect, then flush during stall kills it
        idle();
        valid_i = 1'b1; pc_src_i = 1'b1;
        tick();
        chk_ctl("pc_ctl", 4'b1100);
        idle();
        stall_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1; pc_src_i = 1'b1;
        flag_w_i = 2'b11; alu_flags = 4'b1100;
        tick();
        chk_ctl("fls_stall_ctl", 4'b0000);
        chk("fls_stall_flags", flags_o, 4'b0011);

        // Load reg+mem write, then stall alone holds 3 cycles
        idle();
        valid_i = 1'b1; reg_write_i = 1'b1; mem_write_i = 1'b1;
        tick();
        chk_ctl("rm_ctl", 4'b1011);
        idle();
        stall_i = 1'b1; valid_i = 1'b1; flag_w_i = 2'b11; alu_flags = 4'b1100;
        pc_src_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl($sformatf("stall_ctl%0d", i), 4'b1011);
            chk($sformatf("stall_flags%0d", i), flags_o, 4'b0011);
        end

        // Flush alone
        idle();
        flush_i = 1'b1; valid_i = 1'b1; pc_src_i = 1'b1; flag_w_i = 2'b11;
        alu_flags = 4'b1100;
        tick();
        chk_ctl("flush_ctl", 4'b0000);
        chk("flush_flags", flags_o, 4'b0011);

        // Back-to-back flag writes, each visible the next cycle
        idle();
        valid_i = 1'b1; flag_w_i = 2'b11; alu_flags = 4'b0100;
        tick();
        chk("b2b0_flags", flags_o, 4'b0100);
        alu_flags = 4'b1010;
        tick();
        chk("b2b1_flags", flags_o, 4'b1010);
        // Z=1 N=0 C=1 V=0: GT fails, EQ passes
        idle();
        cond_i = C_GT;
        #1;
        chk("b2b_gt", {3'b000, cond_ex_o}, 4'b0000);
        cond_i = C_EQ;
        #1;
        chk("b2b_eq", {3'b000, cond_ex_o}, 4'b0001);

        // Sticky overflow
        idle();
        valid_i = 1'b1; flag_w_i = 2'b01; alu_flags = 4'b0001;
        tick();
`ifdef COND_STICKY_OVF_EN
        chk("q_set", {3'b000, q_flag_o}, 4'b0001);
        alu_flags = 4'b0000;
        tick();
        chk("q_hold", {3'b000, q_flag_o}, 4'b0001);
        alu_flags = 4'b0001; q_clr_i = 1'b1;
        tick();
        chk("q_set_wins", {3'b000, q_flag_o}, 4'b0001);
        idle();
        q_clr_i = 1'b1;
        tick();
        chk("q_clr", {3'b000, q_flag_o}, 4'b0000);
`else
        chk("q_tied", {3'b000, q_flag_o}, 4'b0000);
`endif
        chk("v_write_flags", flags_o, 4'b1001);

        // Reset mid-stream overrides stall
        idle();
        valid_i = 1'b1; pc_src_i = 1'b1;
        tick();
        chk_ctl("pre_rst_ctl", 4'b1100);
        rst_n = 1'b0; stall_i = 1'b1;
        tick();
        chk_ctl("mid_rst_ctl", 4'b0000);
        chk("mid_rst_flags", flags_o, 4'b0000);
        chk("mid_rst_q", {3'b000, q_flag_o}, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_cond_unit
`default_nettype wire

// File: doc/cond_unit.md
# cond_unit

Conditional-execution stage directly downstream of the ALU in the pipelined ARM-subset processor. Holds the architectural NZCV flags register, which is written from the ALU's 4-bit `alu_flags` output (bit 3 Z, 2 N, 1 C, 0 V). Evaluates the 4-bit instruction condition field against the stored flags and gates the instruction's side effects: PC redirect, register write and memory write. The gated control signals are registered into the EX/MEM boundary.

## Interface
- No parameters; all widths are fixed by the ISA.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `stall_i` in 1: hold all registers.
- `flush_i` in 1: kill the instruction currently in EX.
- `valid_i` in 1: an instruction is present in EX.
- `cond_i` in 4: ARM condition field (instr[31:28]).
- `alu_flags` in 4: ALU flags, Z N C V in bits 3..0.
- `flag_w_i` in 2: [1] writes N,Z; [0] writes C,V.
- `pc_src_i`, `reg_write_i`, `mem_write_i` in 1 each: ungated controls from decode.
- `q_clr_i` in 1: clear the sticky overflow flag (only with the macro).
- `cond_ex_o` out 1: combinational condition-passed.
- `flags_o` out 4: stored flags, same bit order as `alu_flags`.
- `valid_o`, `pc_src_o`, `reg_write_o`, `mem_write_o` out 1 each: registered gated controls.
- `q_flag_o` out 1: sticky overflow.

## Operation
- Condition evaluation uses the stored `flags_o`, never the incoming `alu_flags`:
  - EQ 0000: Z.
  - NE 0001: !Z.
  - CS 0010: C.
  - CC 0011: !C.
  - MI 0100: N.
  - PL 0101: !N.
  - VS 0110: V.
  - VC 0111: !V.
  - HI 1000: C&!Z.
  - LS 1001: !C|Z.
  - GE 1010: N==V.
  - LT 1011: N!=V.
  - GT 1100: !Z&(N==V).
  - LE 1101: Z|(N!=V).
  - AL 1110: 1.
  - 1111 is reserved: `cond_ex_o`=0.
- `exec = valid_i & cond_ex_o & !flush_i`.
- Flag write enables:
  - N,Z update from `alu_flags[2]`, `alu_flags[3]` when `exec & flag_w_i[1] & !stall_i`.
  - C,V update from `alu_flags[1]`, `alu_flags[0]` when `exec & flag_w_i[0] & !stall_i`.
  - The two halves are independent.
- Output register update when `!stall_i`:
  - `valid_o` ← `valid_i & !flush_i`.
  - `pc_src_o` ← `pc_src_i & exec`; `reg_write_o` and `mem_write_o` are gated by `exec` the same way.
  - A failed condition produces a valid no-op (`valid_o`=1, all controls 0).
- Priority: reset > flush > stall.
  - A flush during a stall loads a bubble and suppresses the flag write.
  - `pc_src_o` is produced only here; no other stage drives it.

## Timing
- Reset values: `flags_o`=0000, `valid_o`=0, `pc_src_o`=0, `reg_write_o`=0, `mem_write_o`=0, `q_flag_o`=0.
- Reset asserted mid-stream clears everything at the next edge regardless of `stall_i` or `flush_i`.
- `cond_ex_o` has zero latency: it is combinational from `cond_i` and `flags_o`.
- Gated controls have 1-cycle latency.
- Flags written by instruction k are visible to instruction k+1's `cond_ex_o` in the very next cycle; no forwarding is needed.
- With `stall_i`=1, all registers hold their values indefinitely.
- Back-to-back flag-setting instructions each update on their own edge.

## Configuration
- Macro: `COND_STICKY_OVF_EN`.
- Defined:
  - `q_flag_o` sets on any edge where a C,V write occurs with `alu_flags[0]`=1.
  - It clears on `q_clr_i` when not stalled.
  - Simultaneous set and clear: set wins.
- Undefined:
  - `q_flag_o` is tied to 0 and `q_clr_i` is ignored.
  - No register is inferred.

## Structure
- Package `cond_pkg` contains:
  - `cond_e` enum (EQ..AL, NV).
  - Flag bit index constants `FLAG_Z`=3, `FLAG_N`=2, `FLAG_C`=1, `FLAG_V`=0.
  - Enable bit indices `FLAGW_NZ`=1, `FLAGW_CV`=0.
- One combinational sub-module, `cond_check`: (`cond_i`, flags) → `cond_ex`.
- The flag register, sticky Q and output register live in `cond_unit`.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with all inputs at 1 → all outputs 0, `flags_o`=0000.
- **Flag write:** AL, `flag_w_i`=11, `alu_flags`=1000 → next cycle `flags_o`=1000. Then EQ with `reg_write_i`=1 → `cond_ex_o`=1 and `reg_write_o`=1 one cycle later.
- **Failed condition:** `flags_o`=0100 (N=1, V=0), GE with `mem_write_i`=1 and `flag_w_i`=11 → `cond_ex_o`=0, `valid_o`=1, `mem_write_o`=0, `flags_o` unchanged.
- **Partial write:** `flags_o`=0000, `flag_w_i`=01, `alu_flags`=1111 → `flags_o`=0011.
- **Flush during stall:** both asserted with AL and `pc_src_i`=1 → `valid_o`=0, `pc_src_o`=0, no flag change. Stall alone → outputs held 3 cycles.
- **Sticky Q (macro defined):** CV write with V=1 → `q_flag_o`=1. A later V=0 write leaves it at 1. `q_clr_i` in the same cycle as a V=1 write → stays 1. `q_clr_i` alone → 0.
